// File: rtl/ofs_plat_host_chan_avalon_mem_pkg.sv
// Shared host-channel Avalon definitions: user flag bit positions and the
// write burst splitter state type.
package ofs_plat_host_chan_avalon_mem_pkg;

  localparam int HC_AVALON_UFLAG_NO_REPLY  = 0;
  localparam int HC_AVALON_UFLAG_FENCE     = 1;
  localparam int HC_AVALON_UFLAG_INTERRUPT = 2;
  localparam int HC_AVALON_UFLAG_WIDTH     = 3;

  typedef enum logic {
    WR_SPLIT_PKT_START,
    WR_SPLIT_IN_PKT
  } t_wr_split_state;

endpackage

// File: rtl/ofs_plat_host_chan_avalon_burst_piece_len.sv
// Length of the next legal burst piece: the lesser of the beats remaining and
// the gap to the next naturally aligned max-burst boundary.
module ofs_plat_host_chan_avalon_burst_piece_len #(
  parameter int REM_WIDTH = 7,
  parameter int LEN_WIDTH = 3
) (
  input  logic [LEN_WIDTH-2:0] addr_offset,
  input  logic [REM_WIDTH-1:0] remaining,
  output logic [LEN_WIDTH-1:0] len
);

  localparam int MAX_BURST = 1 << (LEN_WIDTH - 1);

  logic [REM_WIDTH-1:0] gap;

  assign gap = REM_WIDTH'(MAX_BURST) - REM_WIDTH'(addr_offset);
  assign len = (remaining < gap) ? LEN_WIDTH'(remaining) : LEN_WIDTH'(gap);

endmodule

// File: rtl/ofs_plat_host_chan_avalon_wr_burst_splitter.sv
// Splits AFU write bursts into FIU-legal pieces with zero added latency and
// filters the extra FIU write responses so the AFU sees one per packet.
module ofs_plat_host_chan_avalon_wr_burst_splitter
  import ofs_plat_host_chan_avalon_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int USER_WIDTH      = 8,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int FIU_BURST_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,

  input  logic                    s_write,
  output logic                    s_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s_address,
  input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
  input  logic [USER_WIDTH-1:0]   s_user,
  input  logic [DATA_WIDTH-1:0]   s_writedata,
  input  logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic                    s_writeresponsevalid,
  output logic [USER_WIDTH-1:0]   s_writeresponseuser,

  output logic                    m_write,
  input  logic                    m_waitrequest,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [FIU_BURST_WIDTH-1:0] m_burstcount,
  output logic [USER_WIDTH-1:0]   m_user,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic                    m_writeresponsevalid,
  input  logic [USER_WIDTH-1:0]   m_writeresponseuser,

  output logic                    err_bad_cmd,
  output t_wr_split_state         dbg_state
);

  t_wr_split_state state, state_next;

  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [BURST_CNT_WIDTH-1:0] pkt_left_q;
  logic [BURST_CNT_WIDTH-1:0] piece_left_q;
  logic [USER_WIDTH-1:0]      user_q;
  logic [ADDR_WIDTH-1:0]      hold_addr;
  logic [FIU_BURST_WIDTH-1:0] hold_bc;
  logic [USER_WIDTH-1:0]      hold_user;

  logic                       pkt_start;
  logic                       piece_start;
  logic                       beat_accept;
  logic                       is_cmd;
  logic [ADDR_WIDTH-1:0]      cur_addr;
  logic [BURST_CNT_WIDTH-1:0] cur_rem;
  logic [USER_WIDTH-1:0]      cur_user;
  logic [USER_WIDTH-1:0]      start_user;
  logic [FIU_BURST_WIDTH-1:0] split_len;
  logic [BURST_CNT_WIDTH-1:0] piece_len;
  logic [USER_WIDTH-1:0]      resp_user;

  // Handshake: a beat transfers on a cycle where s_write is high and the FIU
  // is not stalling; the stall is reflected straight back to the AFU.
  assign s_waitrequest = m_waitrequest;
  assign m_write       = s_write;
  assign m_writedata   = s_writedata;
  assign m_byteenable  = s_byteenable;
  assign beat_accept   = s_write && !m_waitrequest;
  assign dbg_state     = state;

  ofs_plat_host_chan_avalon_burst_piece_len #(
    .REM_WIDTH (BURST_CNT_WIDTH),
    .LEN_WIDTH (FIU_BURST_WIDTH)
  ) piece_len_i (
    .addr_offset (cur_addr[FIU_BURST_WIDTH-2:0]),
    .remaining   (cur_rem),
    .len         (split_len)
  );

  always_comb begin
    pkt_start   = (state == WR_SPLIT_PKT_START);
    cur_addr    = pkt_start ? s_address : addr_q;
    cur_user    = pkt_start ? s_user : user_q;
    cur_rem     = pkt_start ? ((s_burstcount == '0) ? BURST_CNT_WIDTH'(1) : s_burstcount)
                            : pkt_left_q;
    is_cmd      = cur_user[HC_AVALON_UFLAG_FENCE] || cur_user[HC_AVALON_UFLAG_INTERRUPT];
    // Commands are never split, whatever their length.
    piece_len   = is_cmd ? cur_rem : BURST_CNT_WIDTH'(split_len);
    piece_start = pkt_start || (piece_left_q == '0);

    start_user = cur_user;
    if (!is_cmd && (piece_len < cur_rem)) start_user[HC_AVALON_UFLAG_NO_REPLY] = 1'b1;

    m_address    = piece_start ? cur_addr : hold_addr;
    m_burstcount = piece_start ? FIU_BURST_WIDTH'(piece_len) : hold_bc;
    m_user       = piece_start ? start_user : hold_user;

    state_next = state;
    if (beat_accept) begin
      state_next = (cur_rem == BURST_CNT_WIDTH'(1)) ? WR_SPLIT_PKT_START : WR_SPLIT_IN_PKT;
    end

    resp_user = m_writeresponseuser;
    resp_user[HC_AVALON_UFLAG_NO_REPLY] = 1'b0;
  end

  assign s_writeresponsevalid = m_writeresponsevalid &&
                                !m_writeresponseuser[HC_AVALON_UFLAG_NO_REPLY];
  assign s_writeresponseuser  = resp_user;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WR_SPLIT_PKT_START;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      pkt_left_q   <= '0;
      piece_left_q <= '0;
      user_q       <= '0;
      hold_addr    <= '0;
      hold_bc      <= '0;
      hold_user    <= '0;
      err_bad_cmd  <= 1'b0;
    end else if (beat_accept) begin
      if (piece_start) begin
        hold_addr    <= cur_addr;
        hold_bc      <= FIU_BURST_WIDTH'(piece_len);
        hold_user    <= start_user;
        // Next piece begins right after this one; wraps at the top of the space.
        addr_q       <= cur_addr + ADDR_WIDTH'(piece_len);
        piece_left_q <= piece_len - BURST_CNT_WIDTH'(1);
      end else begin
        piece_left_q <= piece_left_q - BURST_CNT_WIDTH'(1);
      end
      if (pkt_start) begin
        user_q <= s_user;
        if (is_cmd && (cur_rem != BURST_CNT_WIDTH'(1))) err_bad_cmd <= 1'b1;
      end
      pkt_left_q <= cur_rem - BURST_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ofs_plat_host_chan_avalon_wr_burst_splitter.sv
// Bench for the write burst splitter: directed vector table, reset and
// wrap corner cases, then random packets against a piece-list model.
module tb_ofs_plat_host_chan_avalon_wr_burst_splitter;
  import ofs_plat_host_chan_avalon_mem_pkg::*;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int BEW = DW / 8;
  localparam int UW = 8;
  localparam int BW = 7;
  localparam int FW = 3;
  localparam int MAXB = 4;
  localparam int BEAT_W = AW + FW + UW + DW + BEW;
  localparam logic [UW-1:0] NR = 8'h01;
  localparam logic [UW-1:0] FN = 8'h02;
  localparam logic [UW-1:0] IR = 8'h04;

  logic clk;
  logic reset_n;
  logic s_write;
  logic s_waitrequest;
  logic [AW-1:0] s_address;
  logic [BW-1:0] s_burstcount;
  logic [UW-1:0] s_user;
  logic [DW-1:0] s_writedata;
  logic [BEW-1:0] s_byteenable;
  logic s_writeresponsevalid;
  logic [UW-1:0] s_writeresponseuser;
  logic m_write;
  logic m_waitrequest;
  logic [AW-1:0] m_address;
  logic [FW-1:0] m_burstcount;
  logic [UW-1:0] m_user;
  logic [DW-1:0] m_writedata;
  logic [BEW-1:0] m_byteenable;
  logic m_writeresponsevalid;
  logic [UW-1:0] m_writeresponseuser;
  logic err_bad_cmd;
  t_wr_split_state dbg_state;

  int checks = 0;
  int failures = 0;

  logic [BEAT_W-1:0] exp_q[$];
  logic [AW-1:0] pc_addr[$];
  int            pc_len[$];
  logic [UW-1:0] pc_user[$];
  logic [UW-1:0] resp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [UW-1:0] user;
    int            wmode;
    logic          exp_err;
    int            n;
    logic [AW-1:0] pa[3];
    int            pl[3];
    logic [UW-1:0] pu[3];
  } vec_t;

  vec_t vecs[8];

  ofs_plat_host_chan_avalon_wr_burst_splitter dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .s_write              (s_write),
    .s_waitrequest        (s_waitrequest),
    .s_address            (s_address),
    .s_burstcount         (s_burstcount),
    .s_user               (s_user),
    .s_writedata          (s_writedata),
    .s_byteenable         (s_byteenable),
    .s_writeresponsevalid (s_writeresponsevalid),
    .s_writeresponseuser  (s_writeresponseuser),
    .m_write              (m_write),
    .m_waitrequest        (m_waitrequest),
    .m_address            (m_address),
    .m_burstcount         (m_burstcount),
    .m_user               (m_user),
    .m_writedata          (m_writedata),
    .m_byteenable         (m_byteenable),
    .m_writeresponsevalid (m_writeresponsevalid),
    .m_writeresponseuser  (m_writeresponseuser),
    .err_bad_cmd          (err_bad_cmd),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic add_piece(input logic [AW-1:0] a, input int len, input logic [UW-1:0] u);
    pc_addr.push_back(a);
    pc_len.push_back(len);
    pc_user.push_back(u);
  endtask

  // Reference: walk the packet, cutting at every MAXB-aligned boundary.
  task automatic model_pieces(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                              input logic [UW-1:0] user);
    logic [AW-1:0] a;
    int rem;
    int gap;
    int len;
    logic [UW-1:0] u;
    a = addr;
    rem = (bc == 0) ? 1 : int'(bc);
    if ((user & (FN | IR)) != 0) begin
      add_piece(a, rem, user);
    end else begin
      while (rem > 0) begin
        gap = MAXB - int'(a % MAXB);
        len = (rem < gap) ? rem : gap;
        u = (len < rem) ? (user | NR) : user;
        add_piece(a, len, u);
        a = a + AW'(len);
        rem = rem - len;
      end
    end
  endtask

  // driver: wmode 0 = no stall, 1 = stall every other cycle, 2 = random stalls
  task automatic drive_pkt(input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                           input logic [UW-1:0] user, input int wmode, input int stop_after);
    int nb;
    int b;
    int guard;
    int stall;
    logic tog;
    logic wr;
    logic [DW-1:0] dq[$];
    logic [BEW-1:0] bq[$];
    logic [DW-1:0] tmp;
    logic [BEAT_W-1:0] e;
    logic [AW-1:0] pa;
    int pl;
    logic [UW-1:0] pu;
    nb = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < nb; i++) begin
      dq.push_back(rand_wide());
      tmp = rand_wide();
      bq.push_back(tmp[BEW-1:0]);
    end
    b = 0;
    while (pc_addr.size() > 0) begin
      pa = pc_addr.pop_front();
      pl = pc_len.pop_front();
      pu = pc_user.pop_front();
      resp_q.push_back(pu);
      for (int j = 0; j < pl; j++) begin
        if (b < nb) exp_q.push_back({pa, FW'(pl), pu, dq[b], bq[b]});
        b++;
      end
    end
    b = 0;
    guard = 0;
    stall = 0;
    tog = 1'b0;
    while (b < nb && (stop_after == 0 || b < stop_after) && guard < 1000) begin
      @(negedge clk);
      s_write = 1'b1;
      if (b == 0) begin
        s_address = addr;
        s_burstcount = bc;
        s_user = user;
      end else begin
        s_address = {$urandom(), $urandom()};
        s_burstcount = BW'($urandom());
        s_user = UW'($urandom());
      end
      s_writedata = dq[b];
      s_byteenable = bq[b];
      case (wmode)
        1: begin tog = ~tog; wr = tog; end
        2: wr = (stall < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        default: wr = 1'b0;
      endcase
      m_waitrequest = wr;
      #1;
      check("s_waitrequest", s_waitrequest, wr);
      if (!wr) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got beat addr %0h with no expectation", m_address);
        end else begin
          e = exp_q.pop_front();
          check("m_write", m_write, 1'b1);
          check("m_address", m_address, e[BEAT_W-1 -: AW]);
          check("m_burstcount", m_burstcount, e[BEAT_W-AW-1 -: FW]);
          check("m_user", m_user, e[BEAT_W-AW-FW-1 -: UW]);
          check("m_writedata", m_writedata, e[BEW +: DW]);
          check("m_byteenable", m_byteenable, e[BEW-1:0]);
        end
        b++;
        stall = 0;
      end else begin
        stall++;
      end
      @(posedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout: got %0d beats expected %0d", b, nb);
    end
    @(negedge clk);
    s_write = 1'b0;
    m_waitrequest = 1'b0;
  endtask

  task automatic send_resps(input logic [UW-1:0] afu_user);
    int cnt;
    logic [UW-1:0] got;
    cnt = 0;
    got = '0;
    while (resp_q.size() > 0) begin
      @(negedge clk);
      m_writeresponsevalid = 1'b1;
      m_writeresponseuser = resp_q.pop_front();
      #1;
      if (s_writeresponsevalid) begin
        cnt++;
        got = s_writeresponseuser;
      end
    end
    @(negedge clk);
    m_writeresponsevalid = 1'b0;
    m_writeresponseuser = '0;
    check("resp_count", cnt, (afu_user & NR) != 0 ? 0 : 1);
    if ((afu_user & NR) == 0) check("resp_user", got, afu_user & ~NR);
  endtask

  task automatic set_vec(input int i, input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                         input logic [UW-1:0] user, input int wmode, input logic exp_err,
                         input int n,
                         input logic [AW-1:0] a0, input int l0, input logic [UW-1:0] u0,
                         input logic [AW-1:0] a1, input int l1, input logic [UW-1:0] u1,
                         input logic [AW-1:0] a2, input int l2, input logic [UW-1:0] u2);
    vecs[i].addr = addr;
    vecs[i].bc = bc;
    vecs[i].user = user;
    vecs[i].wmode = wmode;
    vecs[i].exp_err = exp_err;
    vecs[i].n = n;
    vecs[i].pa[0] = a0; vecs[i].pl[0] = l0; vecs[i].pu[0] = u0;
    vecs[i].pa[1] = a1; vecs[i].pl[1] = l1; vecs[i].pu[1] = u1;
    vecs[i].pa[2] = a2; vecs[i].pl[2] = l2; vecs[i].pu[2] = u2;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    logic [UW-1:0] ru;

    set_vec(0, 64'h100, 7'd8, 8'h00, 0, 1'b0, 2,
            64'h100, 4, 8'h01, 64'h104, 4, 8'h00, 64'h0, 0, 8'h00);
    set_vec(1, 64'h102, 7'd7, 8'h10, 2, 1'b0, 3,
            64'h102, 2, 8'h11, 64'h104, 4, 8'h11, 64'h108, 1, 8'h10);
    set_vec(2, 64'h200, 7'd3, 8'h00, 1, 1'b0, 1,
            64'h200, 3, 8'h00, 64'h0, 0, 8'h00, 64'h0, 0, 8'h00);
    set_vec(3, 64'h50, 7'd1, FN, 0, 1'b0, 1,
            64'h50, 1, FN, 64'h0, 0, 8'h00, 64'h0, 0, 8'h00);
    set_vec(4, 64'h60, 7'd2, IR, 0, 1'b1, 1,
            64'h60, 2, IR, 64'h0, 0, 8'h00, 64'h0, 0, 8'h00);
    set_vec(5, 64'hFFFF_FFFF_FFFF_FFFE, 7'd4, 8'h00, 0, 1'b1, 2,
            64'hFFFF_FFFF_FFFF_FFFE, 2, 8'h01, 64'h0, 2, 8'h00, 64'h0, 0, 8'h00);
    set_vec(6, 64'h103, 7'd2, 8'h21, 2, 1'b1, 2,
            64'h103, 1, 8'h21, 64'h104, 1, 8'h21, 64'h0, 0, 8'h00);
    set_vec(7, 64'h400, 7'd0, 8'h00, 0, 1'b1, 1,
            64'h400, 1, 8'h00, 64'h0, 0, 8'h00, 64'h0, 0, 8'h00);

    reset_n = 1'b0;
    s_write = 1'b0;
    s_address = '0;
    s_burstcount = '0;
    s_user = '0;
    s_writedata = '0;
    s_byteenable = '0;
    m_waitrequest = 1'b0;
    m_writeresponsevalid = 1'b0;
    m_writeresponseuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", dbg_state, WR_SPLIT_PKT_START);
    check("reset_err", err_bad_cmd, 1'b0);
    check("reset_m_write", m_write, 1'b0);
    check("reset_resp_valid", s_writeresponsevalid, 1'b0);
    reset_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < vecs[i].n; p++) add_piece(vecs[i].pa[p], vecs[i].pl[p], vecs[i].pu[p]);
      drive_pkt(vecs[i].addr, vecs[i].bc, vecs[i].user, vecs[i].wmode, 0);
      check("vec_err_bad_cmd", err_bad_cmd, vecs[i].exp_err);
      check("vec_end_state", dbg_state, WR_SPLIT_PKT_START);
      send_resps(vecs[i].user);
    end

    // reset in the middle of a bc 8 packet, after two beats
    add_piece(64'h100, 4, 8'h01);
    add_piece(64'h104, 4, 8'h00);
    drive_pkt(64'h100, 7'd8, 8'h00, 0, 2);
    check("mid_pkt_state", dbg_state, WR_SPLIT_IN_PKT);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_state", dbg_state, WR_SPLIT_PKT_START);
    check("async_reset_err", err_bad_cmd, 1'b0);
    exp_q.delete();
    resp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    add_piece(64'h300, 1, 8'h00);
    drive_pkt(64'h300, 7'd1, 8'h00, 0, 0);
    check("post_reset_state", dbg_state, WR_SPLIT_PKT_START);
    send_resps(8'h00);

    // random packets against the model
    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(0, 63)))
                                      : {$urandom(), $urandom()};
      rb = BW'($urandom_range(0, 64));
      ru = {3'($urandom()), 2'b00, 2'b00, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0};
      model_pieces(ra, rb, ru);
      drive_pkt(ra, rb, ru, int'($urandom_range(0, 2)), 0);
      check("rand_end_state", dbg_state, WR_SPLIT_PKT_START);
      send_resps(ru);
    end
    check("final_err", err_bad_cmd, 1'b0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
